// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl
//   Frame sequencer for the 3x3 median core. A start pulse clears the core,
//   streams the (WIDTH+1)x(HEIGHT+1) extended frame (last column and last row
//   replicated from the frame edge) out of a synchronous-read source buffer,
//   and writes the WIDTH*HEIGHT core results to a destination buffer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, hold       frame request (IDLE only), read-issue pause
//   busy, done, err   status: not-IDLE, end-of-frame pulse, sticky error
//   src_*             source buffer read port (data one cycle after strobe)
//   core_*            median core reset, input stream, result stream
//   dst_*             destination buffer write port
module median_frame_ctrl #(
  parameter int WIDTH      = 430,
  parameter int HEIGHT     = 554,
  parameter int ADDR_W     = 18,
  parameter int CLR_CYCLES = 2,
  parameter int DRAIN_MAX  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rd_data,
  output logic              core_rst_n,
  output logic              core_in_valid,
  output logic [7:0]        core_pixel_in,
  input  logic              core_out_valid,
  input  logic [7:0]        core_pixel_out,
  input  logic [31:0]       core_out_x,
  input  logic [31:0]       core_out_y,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wr_data
);

  localparam int XW = $clog2(WIDTH + 1) + 1;
  localparam int YW = $clog2(HEIGHT + 1) + 1;
  localparam int CW = $clog2(CLR_CYCLES + 1) + 1;
  localparam int IW = $clog2(DRAIN_MAX + 1) + 1;
  localparam int OW = ADDR_W + 1;

  localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH);
  localparam logic [XW-1:0]     X_EDGE    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT);
  localparam logic [YW-1:0]     Y_EDGE    = YW'(HEIGHT - 1);
  localparam logic [CW-1:0]     CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [IW-1:0]     IDLE_MAX  = IW'(DRAIN_MAX);
  localparam logic [OW-1:0]     OUT_TOTAL = OW'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_BACK  = ADDR_W'(WIDTH - 1);
  localparam logic [31:0]       EXP_X_END = 32'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [XW-1:0]     ex_q, ex_d;
  logic [YW-1:0]     ey_q, ey_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [OW-1:0]     out_cnt_q, out_cnt_d;
  logic [31:0]       exp_x_q, exp_x_d, exp_y_q, exp_y_d;
  logic              err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic              core_rst_n_q, core_rst_n_d, core_in_valid_q, core_in_valid_d;
  logic              dst_wr_en_q, dst_wr_en_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [7:0]        dst_wr_data_q, dst_wr_data_d;

  logic              rd_fire_s, feed_last_s, res_live_s, res_late_s;
  logic              out_full_s, drain_timeout_s;
  logic [IW-1:0]     idle_inc_s;
  logic [31:0]       lin_addr_s;

  // The read strobe follows hold within the same cycle so a paused cycle never issues a read.
  assign rd_fire_s       = (state_q == S_FEED) && !hold;
  assign feed_last_s     = (ex_q == X_LAST) && (ey_q == Y_LAST);
  assign res_live_s      = core_out_valid && ((state_q == S_FEED) || (state_q == S_DRAIN));
  assign out_full_s      = (out_cnt_q == OUT_TOTAL);
  // Results arriving after a complete frame are stray: flag them, never write them.
  assign res_late_s      = core_out_valid && ((state_q == S_DONE) || (state_q == S_IDLE)) && out_full_s;
  assign idle_inc_s      = idle_q + IW'(1);
  assign drain_timeout_s = (state_q == S_DRAIN) && !core_out_valid && (idle_inc_s == IDLE_MAX);
  assign lin_addr_s      = (core_out_y * 32'(WIDTH)) + core_out_x;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR; else state_d = S_IDLE;
      S_CLR:   if (clr_cnt_q == CLR_LAST) state_d = S_FEED; else state_d = S_CLR;
      S_FEED:  if (rd_fire_s && feed_last_s) state_d = S_DRAIN; else state_d = S_FEED;
      S_DRAIN: begin
        if (out_full_s)           state_d = S_DONE;
        else if (drain_timeout_s) state_d = S_DONE;
        else                      state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: status, read walk, result write-back, error tracking.
  always_comb begin
    clr_cnt_d       = (state_q == S_CLR) ? (clr_cnt_q + CW'(1)) : CW'(0);
    ex_d            = ex_q;
    ey_d            = ey_q;
    src_addr_d      = src_addr_q;
    idle_d          = idle_q;
    out_cnt_d       = out_cnt_q;
    exp_x_d         = exp_x_q;
    exp_y_d         = exp_y_q;
    err_d           = err_q;
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    core_rst_n_d    = (state_d != S_CLR);
    core_in_valid_d = rd_fire_s;
    dst_wr_en_d     = 1'b0;
    dst_addr_d      = dst_addr_q;
    dst_wr_data_d   = dst_wr_data_q;

    // Walk the extended frame. The address is tracked incrementally: it stalls
    // on the replicated column and steps back one row for the replicated row.
    if (rd_fire_s) begin
      if (ex_q != X_LAST) begin
        ex_d = ex_q + XW'(1);
        if (ex_q != X_EDGE) src_addr_d = src_addr_q + ADDR_W'(1);
        else                src_addr_d = src_addr_q;
      end else begin
        ex_d = XW'(0);
        if (ey_q == Y_LAST) begin
          ey_d       = YW'(0);
          src_addr_d = ADDR_W'(0);
        end else begin
          ey_d = ey_q + YW'(1);
          if (ey_q == Y_EDGE) src_addr_d = src_addr_q - ROW_BACK;
          else                src_addr_d = src_addr_q + ADDR_W'(1);
        end
      end
    end else begin
      ex_d = ex_q;
    end

    if (res_live_s) begin
      dst_wr_en_d   = 1'b1;
      dst_addr_d    = lin_addr_s[ADDR_W-1:0];
      dst_wr_data_d = core_pixel_out;
      out_cnt_d     = out_cnt_q + OW'(1);
      if ((core_out_x != exp_x_q) || (core_out_y != exp_y_q)) err_d = 1'b1;
      else                                                     err_d = err_q;
      if (exp_x_q == EXP_X_END) begin
        exp_x_d = 32'd0;
        exp_y_d = exp_y_q + 32'd1;
      end else begin
        exp_x_d = exp_x_q + 32'd1;
      end
    end else if (res_late_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (state_q == S_DRAIN) begin
      idle_d = core_out_valid ? IW'(0) : idle_inc_s;
      if (!out_full_s && drain_timeout_s) err_d = 1'b1;
    end else begin
      idle_d = idle_q;
    end

    // An accepted start wins over a stray result in the same cycle.
    if ((state_q == S_IDLE) && start) begin
      ex_d       = XW'(0);
      ey_d       = YW'(0);
      src_addr_d = ADDR_W'(0);
      idle_d     = IW'(0);
      out_cnt_d  = OW'(0);
      exp_x_d    = 32'd0;
      exp_y_d    = 32'd0;
      err_d      = 1'b0;
    end else begin
      out_cnt_d = out_cnt_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q       <= CW'(0);
      ex_q            <= XW'(0);
      ey_q            <= YW'(0);
      src_addr_q      <= ADDR_W'(0);
      idle_q          <= IW'(0);
      out_cnt_q       <= OW'(0);
      exp_x_q         <= 32'd0;
      exp_y_q         <= 32'd0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      core_rst_n_q    <= 1'b1;
      core_in_valid_q <= 1'b0;
      dst_wr_en_q     <= 1'b0;
      dst_addr_q      <= ADDR_W'(0);
      dst_wr_data_q   <= 8'd0;
    end else begin
      clr_cnt_q       <= clr_cnt_d;
      ex_q            <= ex_d;
      ey_q            <= ey_d;
      src_addr_q      <= src_addr_d;
      idle_q          <= idle_d;
      out_cnt_q       <= out_cnt_d;
      exp_x_q         <= exp_x_d;
      exp_y_q         <= exp_y_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      core_rst_n_q    <= core_rst_n_d;
      core_in_valid_q <= core_in_valid_d;
      dst_wr_en_q     <= dst_wr_en_d;
      dst_addr_q      <= dst_addr_d;
      dst_wr_data_q   <= dst_wr_data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign src_rd_en     = rd_fire_s;
  assign src_addr      = src_addr_q;
  assign core_rst_n    = core_rst_n_q;
  assign core_in_valid = core_in_valid_q;
  // Buffer data lands one cycle after the strobe and is forwarded straight to the core.
  assign core_pixel_in = core_in_valid_q ? src_rd_data : 8'd0;
  assign dst_wr_en     = dst_wr_en_q;
  assign dst_addr      = dst_addr_q;
  assign dst_wr_data   = dst_wr_data_q;

endmodule

// File: doc/median_frame_ctrl.md
Name: median_frame_ctrl

Overview:
- Frame-level sequencer for the 3x3 median core.
- On a start pulse it clears the core and reads one source frame from a synchronous-read frame buffer.
- It feeds the core the extended (WIDTH+1)*(HEIGHT+1) stream, with the extra last column and last row replicated from the frame edge.
- It writes the WIDTH*HEIGHT core results to a destination buffer at row-major addresses and reports done, busy and error status.

Parameters:
- WIDTH, 430, frame width in pixels (>=2).
- HEIGHT, 554, frame height in pixels (>=2).
- ADDR_W, 18, source/destination address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- CLR_CYCLES, 2, number of cycles core_rst_n is held low before feeding starts (>=1).
- DRAIN_MAX, 4096, maximum idle cycles in DRAIN without a core output before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  frame start request, sampled only in IDLE.
- hold  in  1  pauses issue of new source reads.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky error flag; cleared by rst or an accepted start.
- src_rd_en  out  1  source read strobe.
- src_addr  out  ADDR_W  source read address.
- src_rd_data  in  8  source data, valid 1 cycle after src_rd_en.
- core_rst_n  out  1  core reset, active-low.
- core_in_valid  out  1  core input strobe.
- core_pixel_in  out  8  core input pixel.
- core_out_valid  in  1  core result strobe.
- core_pixel_out  in  8  core result pixel.
- core_out_x  in  32  core result column.
- core_out_y  in  32  core result row.
- dst_wr_en  out  1  destination write strobe.
- dst_addr  out  ADDR_W  destination write address.
- dst_wr_data  out  8  destination write data.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, err=0, src_rd_en=0, src_addr=0, core_rst_n=1, core_in_valid=0, core_pixel_in=0, dst_wr_en=0, dst_addr=0, dst_wr_data=0. All counters are 0.
- Reset asserted mid-frame aborts at the next edge with no further reads or writes. The core is re-cleared by the next start.
- State IDLE:
  - start=1 -> CLR. This clears err, the ex/ey counters, the output counter and the expected-coordinate counters.
  - start is ignored in every other state.
- State CLR:
  - core_rst_n=0 for exactly CLR_CYCLES cycles, then -> FEED.
- State FEED:
  - Counters ex in 0..WIDTH and ey in 0..HEIGHT run row-major, ex fastest.
  - Each cycle with hold=0: src_rd_en=1, src_addr = min(ey,HEIGHT-1)*WIDTH + min(ex,WIDTH-1), then advance the counters.
  - With hold=1: src_rd_en=0 and the counters are held.
  - Read pipeline: one cycle after every src_rd_en=1, core_in_valid=1 and core_pixel_in=src_rd_data. This happens even if hold has since risen or the state has changed.
  - After issuing the read for ex=WIDTH, ey=HEIGHT -> DRAIN.
- Result handling (FEED and DRAIN):
  - On core_out_valid=1, the next cycle has dst_wr_en=1, dst_addr = core_out_y*WIDTH + core_out_x (truncated to ADDR_W) and dst_wr_data=core_pixel_out.
  - The output counter increments.
  - The result is checked against the expected (x,y) counter, which starts at (0,0) and advances row-major. A mismatch sets err, but the write still occurs.
- State DRAIN:
  - An idle counter resets on each core_out_valid.
  - When the output counter reaches WIDTH*HEIGHT -> DONE.
  - If the idle counter reaches DRAIN_MAX -> set err, -> DONE.
- State DONE:
  - done=1 for one cycle, busy=1, then -> IDLE.
- After the count reaches WIDTH*HEIGHT, any core_out_valid in DONE or IDLE sets err and produces no write.
- Latency:
  - start -> first src_rd_en is CLR_CYCLES+1 cycles.
  - A frame with no hold runs (WIDTH+1)*(HEIGHT+1) feed cycles plus the core drain.

Test Plan:
- WIDTH=4, HEIGHT=3, no hold, start pulse:
  - src_addr sequence is 0,1,2,3,3,4,5,6,7,7,8,9,10,11,11,8,9,10,11,11 (20 reads).
  - core_in_valid is high for 20 cycles, each one cycle after its read.
  - core_rst_n is low for 2 cycles first.
- Same frame against a behavioural core model:
  - exactly 12 dst writes at addresses 0..11 in order;
  - done pulses once, 1 cycle after the 12th write;
  - err=0, busy falls with done.
- hold high for 3 cycles after the 5th read:
  - no src_rd_en during hold;
  - the 5th read's data still reaches the core on the next cycle;
  - the address sequence is unchanged overall.
- Core model stops emitting after 7 results, DRAIN_MAX=16:
  - err=1 after 16 idle DRAIN cycles, then done pulse, return to IDLE;
  - next start clears err.
- Core model reports (2,0) where (1,0) is expected:
  - err=1;
  - the write still goes to address 2.
- start re-asserted during FEED is ignored.
- rst asserted mid-FEED:
  - all outputs return to reset values next cycle, with no further writes;
  - a subsequent start runs a clean full frame.
